// File: rtl/frame_buffer_pkg.sv
// Shared definitions for the frame buffer: FSM encoding, default pixel width
// and the visible-area range test used by both the write and read paths.
package frame_buffer_pkg;

    localparam int unsigned FB_RGB_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } fb_state_e;

    // True when (x,y) lies inside the visible WIDTH x HEIGHT window.
    function automatic logic fb_in_range(input int unsigned x,
                                         input int unsigned y,
                                         input int unsigned width,
                                         input int unsigned height);
        return (x < width) && (y < height);
    endfunction

endpackage

// File: rtl/frame_buffer_ram_if.sv
// Bus bundle for frame_buffer_ram.
//  read  : rd_en, rd_x, rd_y -> rgb, rgb_valid
//  write : wr_valid, wr_x, wr_y, wr_rgb -> wr_ready, wr_drop
//  clear : clr_start, clr_rgb -> busy, clr_done
// slave is the frame buffer side, master is the client side.
interface frame_buffer_ram_if
    import frame_buffer_pkg::*;
#(
    parameter int unsigned AX_W  = 7,
    parameter int unsigned AY_W  = 7,
    parameter int unsigned RGB_W = FB_RGB_W
);
    logic              rd_en;
    logic [AX_W-1:0]   rd_x;
    logic [AY_W-1:0]   rd_y;
    logic [RGB_W-1:0]  rgb;
    logic              rgb_valid;

    logic              wr_valid;
    logic              wr_ready;
    logic [AX_W-1:0]   wr_x;
    logic [AY_W-1:0]   wr_y;
    logic [RGB_W-1:0]  wr_rgb;
    logic              wr_drop;

    logic              clr_start;
    logic [RGB_W-1:0]  clr_rgb;
    logic              busy;
    logic              clr_done;

    modport slave (
        input  rd_en, rd_x, rd_y, wr_valid, wr_x, wr_y, wr_rgb, clr_start, clr_rgb,
        output rgb, rgb_valid, wr_ready, wr_drop, busy, clr_done
    );

    modport master (
        output rd_en, rd_x, rd_y, wr_valid, wr_x, wr_y, wr_rgb, clr_start, clr_rgb,
        input  rgb, rgb_valid, wr_ready, wr_drop, busy, clr_done
    );
endinterface

// File: rtl/frame_buffer_clear_seq.sv
// Raster address generator for the clear engine.
//  clk, rst : clock, synchronous active-high reset
//  start    : zero the counters (takes priority over en)
//  en       : advance one pixel
//  cx, cy   : current pixel coordinate
//  last_c   : current pixel is (WIDTH-1, HEIGHT-1)
module frame_buffer_clear_seq #(
    parameter int unsigned AX_W   = 7,
    parameter int unsigned AY_W   = 7,
    parameter int unsigned WIDTH  = 128,
    parameter int unsigned HEIGHT = 128
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            en,
    output logic [AX_W-1:0] cx,
    output logic [AY_W-1:0] cy,
    output logic            last_c
);

    localparam logic [AX_W-1:0] X_LAST = AX_W'(WIDTH - 1);
    localparam logic [AY_W-1:0] Y_LAST = AY_W'(HEIGHT - 1);

    assign last_c = (cx == X_LAST) && (cy == Y_LAST);

    // Column counter wraps at the visible width and carries into the row.
    always_ff @(posedge clk) begin
        if (rst || start) begin
            cx <= '0;
            cy <= '0;
        end else if (en) begin
            if (cx == X_LAST) begin
                cx <= '0;
                cy <= (cy == Y_LAST) ? '0 : cy + AY_W'(1);
            end else begin
                cx <= cx + AX_W'(1);
            end
        end
    end

endmodule

// File: rtl/frame_buffer_ram.sv
// Dual-port {y,x}-addressed frame buffer with a built-in clear engine.
//  clk, rst : single clock, synchronous active-high reset
//  bus      : frame_buffer_ram_if.slave (read, write handshake, clear control)
// Writes outside the visible window are consumed and flagged on wr_drop;
// reads outside it return BG_RGB. While clearing, the port write path is
// stalled (wr_ready=0) and the clear engine owns the RAM write port.
// Optional build macro: FRAME_BUFFER_OUT_REG_EN adds a second read output
// stage (read latency 2 instead of 1).
module frame_buffer_ram
    import frame_buffer_pkg::*;
#(
    parameter int unsigned      AX_W   = 7,
    parameter int unsigned      AY_W   = 7,
    parameter int unsigned      RGB_W  = FB_RGB_W,
    parameter int unsigned      WIDTH  = 128,
    parameter int unsigned      HEIGHT = 128,
    parameter logic [RGB_W-1:0] BG_RGB = '0
) (
    input  logic               clk,
    input  logic               rst,
    frame_buffer_ram_if.slave  bus
);

    localparam int unsigned A_W   = AX_W + AY_W;
    localparam int unsigned DEPTH = 1 << A_W;

    logic [RGB_W-1:0] mem [DEPTH];

    fb_state_e        state, state_nx;
    logic [RGB_W-1:0] clr_rgb_q;
    logic             busy_q, clr_done_q, wr_drop_q;
    logic             seq_start_c, seq_en_c, seq_last_c;
    logic [AX_W-1:0]  cx;
    logic [AY_W-1:0]  cy;

    logic             wr_ready_c, wr_fire_c, wr_in_c, rd_in_c;
    logic             ram_we_c;
    logic [A_W-1:0]   ram_addr_c;
    logic [RGB_W-1:0] ram_d_c;

    logic [RGB_W-1:0] rgb_q;
    logic             vld_q;

    assign wr_ready_c = (state == ST_IDLE) && !rst;
    assign wr_fire_c  = bus.wr_valid && wr_ready_c;
    assign wr_in_c    = fb_in_range(32'(bus.wr_x), 32'(bus.wr_y), WIDTH, HEIGHT);
    assign rd_in_c    = fb_in_range(32'(bus.rd_x), 32'(bus.rd_y), WIDTH, HEIGHT);

    assign bus.wr_ready = wr_ready_c;
    assign bus.wr_drop  = wr_drop_q;
    assign bus.busy     = busy_q;
    assign bus.clr_done = clr_done_q;

    frame_buffer_clear_seq #(
        .AX_W   (AX_W),
        .AY_W   (AY_W),
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_seq (
        .clk    (clk),
        .rst    (rst),
        .start  (seq_start_c),
        .en     (seq_en_c),
        .cx     (cx),
        .cy     (cy),
        .last_c (seq_last_c)
    );

    // Next-state and sequencer control.
    always_comb begin
        state_nx    = state;
        seq_start_c = 1'b0;
        seq_en_c    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.clr_start) begin
                    state_nx    = ST_CLEAR;
                    seq_start_c = 1'b1;
                end
            end
            ST_CLEAR: begin
                seq_en_c = 1'b1;
                if (seq_last_c) state_nx = ST_DONE;
            end
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // State register and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            busy_q     <= 1'b0;
            clr_done_q <= 1'b0;
            wr_drop_q  <= 1'b0;
        end else begin
            state      <= state_nx;
            busy_q     <= (state_nx != ST_IDLE);
            clr_done_q <= (state_nx == ST_DONE);
            wr_drop_q  <= wr_fire_c && !wr_in_c;
        end
    end

    // Fill colour is captured only on the accepted start.
    always_ff @(posedge clk) begin
        if (seq_start_c && !rst) clr_rgb_q <= bus.clr_rgb;
    end

    // RAM write mux: clear engine has the port while clearing; rst blocks
    // the clear write so a reset edge leaves the next pixel untouched.
    always_comb begin
        ram_we_c   = 1'b0;
        ram_addr_c = {bus.wr_y, bus.wr_x};
        ram_d_c    = bus.wr_rgb;
        if (state == ST_CLEAR) begin
            ram_we_c   = !rst;
            ram_addr_c = {cy, cx};
            ram_d_c    = clr_rgb_q;
        end else if (wr_fire_c && wr_in_c) begin
            ram_we_c = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we_c) mem[ram_addr_c] <= ram_d_c;
    end

    // Read stage 1: old data on a same-address write, BG outside the window.
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q <= '0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= bus.rd_en;
            if (bus.rd_en) rgb_q <= rd_in_c ? mem[{bus.rd_y, bus.rd_x}] : BG_RGB;
        end
    end

`ifdef FRAME_BUFFER_OUT_REG_EN
    logic [RGB_W-1:0] rgb_q2;
    logic             vld_q2;

    // Read stage 2: holds like stage 1, loads only on a valid beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q2 <= '0;
            vld_q2 <= 1'b0;
        end else begin
            vld_q2 <= vld_q;
            if (vld_q) rgb_q2 <= rgb_q;
        end
    end

    assign bus.rgb       = rgb_q2;
    assign bus.rgb_valid = vld_q2;
`else
    assign bus.rgb       = rgb_q;
    assign bus.rgb_valid = vld_q;
`endif

endmodule

// File: tb/tb_frame_buffer_ram.sv
// Self-checking bench for frame_buffer_ram: an 8x8 window instance (a) for
// read/write/clear behaviour and a WIDTH=100 instance (b) for clipping.
module tb_frame_buffer_ram;

`ifdef FRAME_BUFFER_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk;
    logic rst;

    frame_buffer_ram_if #(.AX_W(4), .AY_W(4), .RGB_W(12)) ifa ();
    frame_buffer_ram_if #(.AX_W(7), .AY_W(3), .RGB_W(12)) ifb ();

    frame_buffer_ram #(.AX_W(4), .AY_W(4), .RGB_W(12), .WIDTH(8), .HEIGHT(8),
                       .BG_RGB(12'h5A5)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    frame_buffer_ram #(.AX_W(7), .AY_W(3), .RGB_W(12), .WIDTH(100), .HEIGHT(8),
                       .BG_RGB(12'hBEE)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [11:0] exp_q[$];
    logic [11:0] mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Scoreboard: each read beat on instance a is matched against the queue.
    always @(negedge clk) begin
        if (ifa.rgb_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("rd_extra_valid", 32'(ifa.rgb_valid), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rd_data", 32'(ifa.rgb), 32'(mon_e));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic a_wr(input int x, input int y, input logic [11:0] d, input logic drop);
        ifa.wr_valid = 1'b1;
        ifa.wr_x     = 4'(x);
        ifa.wr_y     = 4'(y);
        ifa.wr_rgb   = d;
        chk("wr_ready", 32'(ifa.wr_ready), 32'd1);
        tick();
        ifa.wr_valid = 1'b0;
        chk("wr_drop", 32'(ifa.wr_drop), 32'(drop));
    endtask

    task automatic a_rd(input int x, input int y, input logic [11:0] e);
        ifa.rd_en = 1'b1;
        ifa.rd_x  = 4'(x);
        ifa.rd_y  = 4'(y);
        exp_q.push_back(e);
        tick();
        ifa.rd_en = 1'b0;
    endtask

    task automatic drain();
        repeat (LAT + 1) tick();
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
    endtask

    typedef struct {
        logic        wr;
        int          x;
        int          y;
        logic [11:0] d;
        logic [11:0] exp_rgb;
        logic        exp_drop;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int n_busy, n_done, done_at;
        logic [11:0] old56, old15, oldb;

        vecs[0]  = '{1'b1, 0,  0,  12'h001, 12'h000, 1'b0};
        vecs[1]  = '{1'b1, 7,  7,  12'h077, 12'h000, 1'b0};
        vecs[2]  = '{1'b1, 8,  3,  12'hEEE, 12'h000, 1'b1};
        vecs[3]  = '{1'b1, 3,  8,  12'hEEE, 12'h000, 1'b1};
        vecs[4]  = '{1'b1, 15, 15, 12'hEEE, 12'h000, 1'b1};
        vecs[5]  = '{1'b1, 7,  0,  12'h070, 12'h000, 1'b0};
        vecs[6]  = '{1'b0, 0,  0,  12'h000, 12'h001, 1'b0};
        vecs[7]  = '{1'b0, 7,  7,  12'h000, 12'h077, 1'b0};
        vecs[8]  = '{1'b0, 7,  0,  12'h000, 12'h070, 1'b0};
        vecs[9]  = '{1'b0, 0,  7,  12'h000, 12'h0F0, 1'b0};
        vecs[10] = '{1'b0, 8,  3,  12'h000, 12'h5A5, 1'b0};
        vecs[11] = '{1'b0, 3,  8,  12'h000, 12'h5A5, 1'b0};
        vecs[12] = '{1'b0, 15, 15, 12'h000, 12'h5A5, 1'b0};
        vecs[13] = '{1'b0, 6,  7,  12'h000, 12'h0F0, 1'b0};

        rst = 1'b1;
        ifa.rd_en = 0; ifa.rd_x = 0; ifa.rd_y = 0; ifa.wr_valid = 0; ifa.wr_x = 0;
        ifa.wr_y = 0; ifa.wr_rgb = 0; ifa.clr_start = 0; ifa.clr_rgb = 0;
        ifb.rd_en = 0; ifb.rd_x = 0; ifb.rd_y = 0; ifb.wr_valid = 0; ifb.wr_x = 0;
        ifb.wr_y = 0; ifb.wr_rgb = 0; ifb.clr_start = 0; ifb.clr_rgb = 0;

        // Reset values.
        repeat (3) tick();
        chk("rst_rgb",       32'(ifa.rgb),       32'd0);
        chk("rst_rgb_valid", 32'(ifa.rgb_valid), 32'd0);
        chk("rst_wr_ready",  32'(ifa.wr_ready),  32'd0);
        chk("rst_wr_drop",   32'(ifa.wr_drop),   32'd0);
        chk("rst_busy",      32'(ifa.busy),      32'd0);
        chk("rst_clr_done",  32'(ifa.clr_done),  32'd0);
        chk("rst_b_rgb",     32'(ifb.rgb),       32'd0);
        rst = 1'b0;
        tick();
        chk("idle_wr_ready", 32'(ifa.wr_ready), 32'd1);

        // Basic write then read with latency check.
        a_wr(3, 5, 12'hABC, 1'b0);
        chk("lat0", 32'(ifa.rgb_valid), 32'd0);
        a_rd(3, 5, 12'hABC);
        for (int k = 1; k <= 3; k++) begin
            chk("rd_latency", 32'(ifa.rgb_valid), 32'(k == LAT));
            tick();
        end

        // Clear with a simultaneous write; write and restart attempts mid-clear.
        old56 = dut_a.mem[56];
        old15 = dut_a.mem[15];
        ifa.clr_start = 1'b1;
        ifa.clr_rgb   = 12'h0F0;
        ifa.wr_valid  = 1'b1;
        ifa.wr_x = 4'd1; ifa.wr_y = 4'd1; ifa.wr_rgb = 12'h111;
        tick();
        ifa.clr_start = 1'b0;
        ifa.wr_valid  = 1'b0;
        n_busy = 0; n_done = 0; done_at = 0;
        for (int k = 1; k <= 200; k++) begin
            if (ifa.busy) n_busy++;
            if (ifa.clr_done) begin
                n_done++;
                done_at = n_busy;
            end
            if (k > 1 && !ifa.busy) break;
            ifa.wr_valid  = 1'b0;
            ifa.clr_start = 1'b0;
            ifa.rd_en     = 1'b0;
            if (k == 2) begin
                ifa.rd_en = 1'b1; ifa.rd_x = 4'd3; ifa.rd_y = 4'd5;
                exp_q.push_back(12'hABC);
            end
            if (k == 3) begin
                ifa.wr_valid = 1'b1;
                ifa.wr_x = 4'd0; ifa.wr_y = 4'd0; ifa.wr_rgb = 12'h222;
                ifa.clr_start = 1'b1;
                ifa.clr_rgb   = 12'h00F;
                chk("clear_wr_ready", 32'(ifa.wr_ready), 32'd0);
            end
            tick();
        end
        ifa.wr_valid = 1'b0; ifa.clr_start = 1'b0; ifa.rd_en = 1'b0;
        chk("busy_cycles",  32'(n_busy),  32'd65);
        chk("clr_done_cnt", 32'(n_done),  32'd1);
        chk("clr_done_at",  32'(done_at), 32'd65);
        chk("post_clear_wr_ready", 32'(ifa.wr_ready), 32'd1);
        for (int i = 0; i < 64; i++) a_rd(i % 8, i / 8, 12'h0F0);
        drain();
        chk("clip_pixel_56", 32'(dut_a.mem[56]), 32'(old56));
        chk("clip_pixel_15", 32'(dut_a.mem[15]), 32'(old15));

        // Table-driven writes and reads including window boundaries.
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].wr) a_wr(vecs[i].x, vecs[i].y, vecs[i].d, vecs[i].exp_drop);
            else            a_rd(vecs[i].x, vecs[i].y, vecs[i].exp_rgb);
        end
        drain();
        chk("drop_ram_unchanged", 32'(dut_a.mem[56]), 32'(old56));

        // Same-cycle read and write to (2,2).
        ifa.rd_en = 1'b1; ifa.rd_x = 4'd2; ifa.rd_y = 4'd2;
        ifa.wr_valid = 1'b1; ifa.wr_x = 4'd2; ifa.wr_y = 4'd2; ifa.wr_rgb = 12'h222;
        exp_q.push_back(12'h0F0);
        tick();
        ifa.wr_valid = 1'b0;
        exp_q.push_back(12'h222);
        tick();
        ifa.rd_en = 1'b0;
        drain();

        // Reset during a clear after 10 pixels.
        for (int i = 0; i < 64; i++) a_wr(i % 8, i / 8, 12'(12'h300 + i), 1'b0);
        ifa.clr_start = 1'b1;
        ifa.clr_rgb   = 12'hF00;
        tick();
        ifa.clr_start = 1'b0;
        n_done = 0;
        for (int k = 0; k < 10; k++) begin
            if (ifa.clr_done) n_done++;
            tick();
        end
        chk("midclear_busy", 32'(ifa.busy), 32'd1);
        rst = 1'b1;
        tick();
        if (ifa.clr_done) n_done++;
        chk("rst_clear_busy", 32'(ifa.busy), 32'd0);
        rst = 1'b0;
        tick();
        if (ifa.clr_done) n_done++;
        chk("rst_clear_no_done", 32'(n_done), 32'd0);
        chk("rst_clear_wr_ready", 32'(ifa.wr_ready), 32'd1);
        chk("rst_clear_idle", 32'(ifa.busy), 32'd0);
        for (int i = 0; i < 64; i++)
            a_rd(i % 8, i / 8, (i < 10) ? 12'hF00 : 12'(12'h300 + i));
        drain();

        // WIDTH=100 instance: in-range write, clipped write, BG read.
        ifb.wr_valid = 1'b1; ifb.wr_x = 7'd5; ifb.wr_y = 3'd2; ifb.wr_rgb = 12'h123;
        tick();
        chk("b_wr_nodrop", 32'(ifb.wr_drop), 32'd0);
        ifb.wr_x = 7'd99; ifb.wr_y = 3'd7; ifb.wr_rgb = 12'h456;
        tick();
        chk("b_wr_edge_nodrop", 32'(ifb.wr_drop), 32'd0);
        oldb = dut_b.mem[100];
        ifb.wr_x = 7'd100; ifb.wr_y = 3'd0; ifb.wr_rgb = 12'hFFF;
        chk("b_wr_ready", 32'(ifb.wr_ready), 32'd1);
        tick();
        ifb.wr_valid = 1'b0;
        chk("b_wr_drop", 32'(ifb.wr_drop), 32'd1);
        tick();
        chk("b_wr_drop_pulse", 32'(ifb.wr_drop), 32'd0);
        chk("b_drop_ram", 32'(dut_b.mem[100]), 32'(oldb));

        ifb.rd_en = 1'b1; ifb.rd_x = 7'd120; ifb.rd_y = 3'd7;
        tick();
        ifb.rd_en = 1'b0;
        repeat (LAT - 1) tick();
        chk("b_bg_valid", 32'(ifb.rgb_valid), 32'd1);
        chk("b_bg_rgb",   32'(ifb.rgb),       32'hBEE);

        ifb.rd_en = 1'b1; ifb.rd_x = 7'd5; ifb.rd_y = 3'd2;
        tick();
        ifb.rd_x = 7'd99; ifb.rd_y = 3'd7;
        if (LAT == 1) chk("b_rd_5_2", 32'(ifb.rgb), 32'h123);
        tick();
        ifb.rd_en = 1'b0;
        if (LAT == 2) chk("b_rd_5_2", 32'(ifb.rgb), 32'h123);
        repeat (LAT - 1) tick();
        chk("b_rd_99_7", 32'(ifb.rgb), 32'h456);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
